elm_inference_sequencer: RTL and testbench

Top-level sequencer for the Extreme Learning Machine inference pipeline. It takes one `start` request, launches the three stage controllers in order (M1 hidden-layer MAC/activation, M2 output-layer MAC, M3 argmax/digit select) and waits for each stage's done. It then latches the classified digit and presents it with a valid flag until the next request. A per-stage watchdog turns a stalled stage into a reported error. An `abort` input returns the pipeline to idle from any state.

---
 rtl/elm_inference_sequencer_pkg.sv | 39 +++
 rtl/elm_inference_sequencer_if.sv | 37 +++
 rtl/elm_inference_sequencer_watchdog.sv | 31 +++
 rtl/elm_inference_sequencer.sv | 96 +++++++++
 tb/tb_elm_inference_sequencer.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/elm_inference_sequencer_pkg.sv
// elm_seq_pkg: shared types and constants for the ELM inference sequencer.
//   state_t            sequencer FSM states
//   stage_t / STG_*    stage identifiers reported on err_stage
//   DEFAULT_TIMEOUT_CYCLES  default per-stage watchdog limit
//   stage_of / is_run  helpers mapping a state to its stage and run status
package elm_seq_pkg;

  localparam int DEFAULT_TIMEOUT_CYCLES = 50000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN_M1,
    ST_RUN_M2,
    ST_RUN_M3,
    ST_DONE,
    ST_ERR
  } state_t;

  typedef logic [1:0] stage_t;

  localparam stage_t STG_NONE = 2'd0;
  localparam stage_t STG_M1   = 2'd1;
  localparam stage_t STG_M2   = 2'd2;
  localparam stage_t STG_M3   = 2'd3;

  function automatic stage_t stage_of(input state_t s);
    case (s)
      ST_RUN_M1: return STG_M1;
      ST_RUN_M2: return STG_M2;
      ST_RUN_M3: return STG_M3;
      default:   return STG_NONE;
    endcase
  endfunction

  function automatic logic is_run(input state_t s);
    return (s == ST_RUN_M1) || (s == ST_RUN_M2) || (s == ST_RUN_M3);
  endfunction

endpackage

// File: rtl/elm_inference_sequencer_if.sv
// elm_inference_sequencer_if: request, stage handshake and result signals
// of the inference sequencer.
//   master modport: the requester / stage side (drives start, abort, dones,
//                   digit_in; observes go pulses and results)
//   slave modport:  the sequencer itself
interface elm_inference_sequencer_if #(
  parameter int DIGIT_W = 4,
  parameter int FRAME_W = 16
);
  logic               start;
  logic               abort;
  logic               m1_done;
  logic               m2_done;
  logic               m3_done;
  logic [DIGIT_W-1:0] digit_in;
  logic               m1_go;
  logic               m2_go;
  logic               m3_go;
  logic               busy;
  logic               result_valid;
  logic [DIGIT_W-1:0] result_digit;
  logic               error;
  logic [1:0]         err_stage;
  logic [FRAME_W-1:0] frame_count;

  modport master (
    output start, abort, m1_done, m2_done, m3_done, digit_in,
    input  m1_go, m2_go, m3_go, busy, result_valid, result_digit,
           error, err_stage, frame_count
  );

  modport slave (
    input  start, abort, m1_done, m2_done, m3_done, digit_in,
    output m1_go, m2_go, m3_go, busy, result_valid, result_digit,
           error, err_stage, frame_count
  );
endinterface

// File: rtl/elm_inference_sequencer_watchdog.sv
// elm_stage_watchdog: per-stage cycle counter.
//   clk, rst  clock / synchronous active-high reset
//   clr       zero the count (wins over en); asserted on the edge entering a stage
//   en        count one cycle; high while a stage is running
//   expired   high in the TIMEOUT_CYCLES-th cycle of the running stage
module elm_stage_watchdog
  import elm_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int TIMEOUT_W      = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  logic [TIMEOUT_W-1:0] count;

  // NOTE: reset is synchronous (sampled only on clk) and all state updates use <=.
  always_ff @(posedge clk) begin
    if (rst)      count <= '0;
    else if (clr) count <= '0;
    else if (en)  count <= count + 1'b1;
  end

  // The stage leaves its RUN state on the following edge, so count never passes LAST.
  assign expired = en && (count == LAST);
endmodule

// File: rtl/elm_inference_sequencer.sv
// elm_inference_sequencer: launches ELM stages M1 -> M2 -> M3 for one start
// request, latches the argmax digit, and reports per-stage timeouts.
//   clk, rst  clock / synchronous active-high reset
//   bus       slave side of elm_inference_sequencer_if:
//             in  start, abort, m1/m2/m3_done, digit_in
//             out m1/m2/m3_go (one-cycle launch), busy, result_valid,
//                 result_digit, error, err_stage, frame_count
// All outputs are registered from the next-state value.
module elm_inference_sequencer
  import elm_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int TIMEOUT_W      = 16,
  parameter int DIGIT_W        = 4,
  parameter int FRAME_W        = 16
) (
  input logic                      clk,
  input logic                      rst,
  elm_inference_sequencer_if.slave bus
);
  state_t state, state_nxt;
  logic   wd_clr, wd_en, wd_expired;
  logic   entering_run;

  elm_stage_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TIMEOUT_W     (TIMEOUT_W)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (wd_clr),
    .en     (wd_en),
    .expired(wd_expired)
  );

  // Abort outranks done, done outranks timeout; only the active stage's done counts.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    if (bus.abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (bus.start) state_nxt = ST_RUN_M1;
        ST_RUN_M1: if (bus.m1_done) state_nxt = ST_RUN_M2;
                   else if (wd_expired) state_nxt = ST_ERR;
        ST_RUN_M2: if (bus.m2_done) state_nxt = ST_RUN_M3;
                   else if (wd_expired) state_nxt = ST_ERR;
        ST_RUN_M3: if (bus.m3_done) state_nxt = ST_DONE;
                   else if (wd_expired) state_nxt = ST_ERR;
        ST_DONE,
        ST_ERR:    if (bus.start) state_nxt = ST_RUN_M1;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  // Entry into a RUN state: the go pulse and the watchdog clear share this edge.
  assign entering_run = is_run(state_nxt) && (state_nxt != state);
  assign wd_clr       = entering_run;
  assign wd_en        = is_run(state);

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      bus.m1_go        <= 1'b0;
      bus.m2_go        <= 1'b0;
      bus.m3_go        <= 1'b0;
      bus.busy         <= 1'b0;
      bus.result_valid <= 1'b0;
      bus.result_digit <= '0;
      bus.error        <= 1'b0;
      bus.err_stage    <= STG_NONE;
      bus.frame_count  <= '0;
    end else begin
      state            <= state_nxt;
      bus.m1_go        <= entering_run && (state_nxt == ST_RUN_M1);
      bus.m2_go        <= entering_run && (state_nxt == ST_RUN_M2);
      bus.m3_go        <= entering_run && (state_nxt == ST_RUN_M3);
      bus.busy         <= is_run(state_nxt);
      bus.result_valid <= (state_nxt == ST_DONE);
      bus.error        <= (state_nxt == ST_ERR);

      if ((state == ST_RUN_M3) && (state_nxt == ST_DONE)) begin
        bus.result_digit <= bus.digit_in;
        bus.frame_count  <= bus.frame_count + 1'b1;
      end

      // err_stage survives abort as a diagnostic; only a relaunch from ERR clears it.
      if ((state_nxt == ST_ERR) && (state != ST_ERR))
        bus.err_stage <= stage_of(state);
      else if ((state == ST_ERR) && (state_nxt == ST_RUN_M1))
        bus.err_stage <= STG_NONE;
    end
  end
endmodule

// File: tb/tb_elm_inference_sequencer.sv
// Directed bench for elm_inference_sequencer with TIMEOUT_CYCLES=20.
// A second instance with FRAME_W=2 shares every input so the frame counter
// wrap is observed without a preload port.
module tb_elm_inference_sequencer;
  localparam int TO = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int vecs  = 0;
  int fails = 0;
  int g1 = 0, g2 = 0, g3 = 0;
  int g1s, g2s, g3s;

  elm_inference_sequencer_if #(.DIGIT_W(4), .FRAME_W(16)) bus ();
  elm_inference_sequencer_if #(.DIGIT_W(4), .FRAME_W(2))  wbus ();

  assign wbus.start    = bus.start;
  assign wbus.abort    = bus.abort;
  assign wbus.m1_done  = bus.m1_done;
  assign wbus.m2_done  = bus.m2_done;
  assign wbus.m3_done  = bus.m3_done;
  assign wbus.digit_in = bus.digit_in;

  elm_inference_sequencer #(
    .TIMEOUT_CYCLES(TO), .TIMEOUT_W(5), .DIGIT_W(4), .FRAME_W(16)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  elm_inference_sequencer #(
    .TIMEOUT_CYCLES(TO), .TIMEOUT_W(5), .DIGIT_W(4), .FRAME_W(2)
  ) dut_wrap (
    .clk(clk), .rst(rst), .bus(wbus)
  );

  // Go-pulse tally, sampled mid-cycle.
  always @(negedge clk) begin
    g1 = g1 + int'(bus.m1_go);
    g2 = g2 + int'(bus.m2_go);
    g3 = g3 + int'(bus.m3_go);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hold the done of stage stg low for lat cycles, then pulse it for one cycle.
  task automatic run_done(input int stg, input int lat);
    repeat (lat) tick();
    case (stg)
      1: bus.m1_done = 1'b1;
      2: bus.m2_done = 1'b1;
      default: bus.m3_done = 1'b1;
    endcase
    tick();
    bus.m1_done = 1'b0;
    bus.m2_done = 1'b0;
    bus.m3_done = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    bus.m1_done  = 1'b0;
    bus.m2_done  = 1'b0;
    bus.m3_done  = 1'b0;
    bus.digit_in = 4'hF;

    // Reset values
    rst = 1'b1;
    repeat (2) tick();
    check("rst_busy",   32'(bus.busy), 0);
    check("rst_valid",  32'(bus.result_valid), 0);
    check("rst_error",  32'(bus.error), 0);
    check("rst_stage",  32'(bus.err_stage), 0);
    check("rst_frame",  32'(bus.frame_count), 0);
    check("rst_digit",  32'(bus.result_digit), 0);
    check("rst_go",     32'({bus.m1_go, bus.m2_go, bus.m3_go}), 0);
    rst = 1'b0;
    tick();
    check("idle_busy", 32'(bus.busy), 0);

    // Nominal run: dones 3 cycles after each go, valid at start+13
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("nom_m1_go", 32'(bus.m1_go), 1);
    check("nom_busy",  32'(bus.busy), 1);
    run_done(1, 3);
    check("nom_m2_go", 32'(bus.m2_go), 1);
    check("nom_m1_go_low", 32'(bus.m1_go), 0);
    run_done(2, 3);
    check("nom_m3_go", 32'(bus.m3_go), 1);
    repeat (3) tick();
    check("nom_pre_valid", 32'(bus.result_valid), 0);
    bus.digit_in = 4'd7;
    bus.m3_done  = 1'b1;
    tick();
    bus.m3_done  = 1'b0;
    bus.digit_in = 4'hF;
    check("nom_valid", 32'(bus.result_valid), 1);
    check("nom_digit", 32'(bus.result_digit), 7);
    check("nom_frame", 32'(bus.frame_count), 1);
    check("nom_busy_low", 32'(bus.busy), 0);
    tick();
    check("nom_hold_valid", 32'(bus.result_valid), 1);
    check("nom_hold_digit", 32'(bus.result_digit), 7);
    check("nom_go_count", 32'({g1[7:0], g2[7:0], g3[7:0]}), 32'h010101);

    // Back-to-back from DONE, minimum-latency stages
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("b2b_valid_fall", 32'(bus.result_valid), 0);
    check("b2b_m1_go", 32'(bus.m1_go), 1);
    run_done(1, 0);
    check("b2b_m2_go", 32'(bus.m2_go), 1);
    run_done(2, 0);
    check("b2b_m3_go", 32'(bus.m3_go), 1);
    bus.digit_in = 4'd2;
    run_done(3, 0);
    bus.digit_in = 4'hF;
    check("b2b_valid", 32'(bus.result_valid), 1);
    check("b2b_digit", 32'(bus.result_digit), 2);
    check("b2b_frame", 32'(bus.frame_count), 2);

    // Spurious done in RUN_M1, start during RUN_M2
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    g2s = g2;
    g3s = g3;
    bus.m3_done = 1'b1;
    tick();
    tick();
    bus.m3_done = 1'b0;
    check("spur_busy", 32'(bus.busy), 1);
    check("spur_go_levels", 32'({bus.m2_go, bus.m3_go}), 0);
    check("spur_go_counts", 32'({g2 - g2s, g3 - g3s}), 0);
    run_done(1, 0);
    check("spur_m2_go", 32'(bus.m2_go), 1);
    g1s = g1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("spur_start_m1_go", 32'(bus.m1_go), 0);
    tick();
    check("spur_start_busy", 32'(bus.busy), 1);
    check("spur_start_count", 32'(g1 - g1s), 0);
    run_done(2, 0);
    bus.digit_in = 4'd5;
    run_done(3, 0);
    bus.digit_in = 4'hF;
    check("spur_digit", 32'(bus.result_digit), 5);
    check("spur_frame", 32'(bus.frame_count), 3);
    check("wrap_all_ones", 32'(wbus.frame_count), 3);

    // Timeout in M2: ERR exactly TO cycles after m2_go
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    run_done(1, 0);
    check("to_m2_go", 32'(bus.m2_go), 1);
    repeat (TO - 1) tick();
    check("to_pre_error", 32'(bus.error), 0);
    check("to_pre_busy", 32'(bus.busy), 1);
    tick();
    check("to_error", 32'(bus.error), 1);
    check("to_stage", 32'(bus.err_stage), 2);
    check("to_busy", 32'(bus.busy), 0);
    tick();
    check("to_hold", 32'({bus.error, bus.err_stage}), 32'h6);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("to_clear_stage", 32'(bus.err_stage), 0);
    check("to_clear_error", 32'(bus.error), 0);
    check("to_relaunch", 32'(bus.m1_go), 1);
    check("to_frame_kept", 32'(bus.frame_count), 3);

    // Done in the timeout cycle completes the stage normally
    repeat (TO - 1) tick();
    bus.m1_done = 1'b1;
    tick();
    bus.m1_done = 1'b0;
    check("col_m2_go", 32'(bus.m2_go), 1);
    check("col_error", 32'(bus.error), 0);
    check("col_stage", 32'(bus.err_stage), 0);
    run_done(2, 0);
    bus.digit_in = 4'd9;
    run_done(3, 0);
    bus.digit_in = 4'hF;
    check("col_digit", 32'(bus.result_digit), 9);
    check("col_frame", 32'(bus.frame_count), 4);
    check("wrap_zero", 32'(wbus.frame_count), 0);

    // Abort in RUN_M3, colliding with m3_done
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    run_done(1, 0);
    run_done(2, 0);
    check("ab_m3_go", 32'(bus.m3_go), 1);
    bus.abort    = 1'b1;
    bus.m3_done  = 1'b1;
    bus.digit_in = 4'd3;
    tick();
    bus.abort    = 1'b0;
    bus.m3_done  = 1'b0;
    bus.digit_in = 4'hF;
    check("ab_busy", 32'(bus.busy), 0);
    check("ab_valid", 32'(bus.result_valid), 0);
    check("ab_frame", 32'(bus.frame_count), 4);
    check("ab_digit", 32'(bus.result_digit), 9);
    check("ab_go", 32'({bus.m1_go, bus.m2_go, bus.m3_go}), 0);
    tick();
    check("ab_idle", 32'(bus.busy), 0);

    // Reset mid-run with a pending done
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    run_done(1, 1);
    rst = 1'b1;
    bus.m2_done = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_outputs", 32'({bus.busy, bus.result_valid, bus.error, bus.err_stage,
                              bus.m1_go, bus.m2_go, bus.m3_go}), 0);
    check("mrst_frame", 32'(bus.frame_count), 0);
    check("mrst_digit", 32'(bus.result_digit), 0);
    tick();
    bus.m2_done = 1'b0;
    check("mrst_ignore_done", 32'({bus.busy, bus.m3_go}), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule
